// File: rtl/spu_ma_ldrtn_if.sv
// Load-FSM handshake, CPX return and MA memory write signals for spu_ma_ldrtn.
// SPU_LDRTN_PARITY_EN adds the per-byte even-parity write lane.
interface spu_ma_ldrtn_if #(
    parameter int LINE_W = 128,
    parameter int WORD_W = 64
);
    logic              spu_mald_ldreq;
    logic              lsu_spu_ldreq_ack;
    logic              cpx_spu_rtn_vld;
    logic              cpx_spu_rtn_ld;
    logic [LINE_W-1:0] cpx_spu_rtn_data;
    logic              cpx_spu_rtn_unc;
    logic              cpx_spu_rtn_cor;
    logic              spu_ldrtn_abort;
    logic              spu_ldrtn_ln_received;
    logic              spu_ldrtn_unc_err_pulse;
    logic              spu_ldrtn_cor_err_pulse;
    logic              spu_ldrtn_memwen;
    logic              spu_ldrtn_memwr_word;
    logic [WORD_W-1:0] spu_ldrtn_memwr_data;
    logic              spu_ldrtn_ld_inprog;
    logic              spu_ldrtn_stale_drop;
`ifdef SPU_LDRTN_PARITY_EN
    logic [WORD_W/8-1:0] spu_ldrtn_memwr_par;
`endif

    modport master (
        output spu_mald_ldreq, lsu_spu_ldreq_ack, cpx_spu_rtn_vld, cpx_spu_rtn_ld,
        output cpx_spu_rtn_data, cpx_spu_rtn_unc, cpx_spu_rtn_cor, spu_ldrtn_abort,
`ifdef SPU_LDRTN_PARITY_EN
        input  spu_ldrtn_memwr_par,
`endif
        input  spu_ldrtn_ln_received, spu_ldrtn_unc_err_pulse, spu_ldrtn_cor_err_pulse,
        input  spu_ldrtn_memwen, spu_ldrtn_memwr_word, spu_ldrtn_memwr_data,
        input  spu_ldrtn_ld_inprog, spu_ldrtn_stale_drop
    );

    modport slave (
        input  spu_mald_ldreq, lsu_spu_ldreq_ack, cpx_spu_rtn_vld, cpx_spu_rtn_ld,
        input  cpx_spu_rtn_data, cpx_spu_rtn_unc, cpx_spu_rtn_cor, spu_ldrtn_abort,
`ifdef SPU_LDRTN_PARITY_EN
        output spu_ldrtn_memwr_par,
`endif
        output spu_ldrtn_ln_received, spu_ldrtn_unc_err_pulse, spu_ldrtn_cor_err_pulse,
        output spu_ldrtn_memwen, spu_ldrtn_memwr_word, spu_ldrtn_memwr_data,
        output spu_ldrtn_ld_inprog, spu_ldrtn_stale_drop
    );
endinterface

// File: rtl/spu_ma_ldrtn.sv
// SPU MA load-return stage: tracks one outstanding line request, buffers the L2 return and
// streams it to MA memory as two words. SPU_LDRTN_PARITY_EN adds a registered parity stage.
module spu_ma_ldrtn #(
    parameter int LINE_W = 128,
    parameter int WORD_W = 64
) (
    input  logic          rclk,
    input  logic          arst_l,
    spu_ma_ldrtn_if.slave bus
);
    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_WAIT = 5'b00010;
    localparam logic [4:0] ST_WR0  = 5'b00100;
    localparam logic [4:0] ST_WR1  = 5'b01000;
    localparam logic [4:0] ST_DONE = 5'b10000;

    logic [4:0]        state_r;
    logic [4:0]        state_nxt_s;
    logic [LINE_W-1:0] buf_r;
    logic              ret_s;
    logic              accept_s;
    logic              abort_s;
    logic              wen_nxt_s, word_nxt_s, ln_nxt_s, unc_nxt_s, cor_nxt_s, inprog_nxt_s, stale_nxt_s;
    logic              wen_r, word_r, ln_r, unc_r, cor_r, inprog_r, stale_r;
    logic [WORD_W-1:0] data_s;
    logic              wen1_s;
    logic [WORD_W-1:0] data1_s;
    logic              wen_out_s;
    logic              word_out_s;
    logic              ln_out_s;
    logic [WORD_W-1:0] data_out_s;

    assign abort_s  = bus.spu_ldrtn_abort;
    assign ret_s    = bus.cpx_spu_rtn_vld & bus.cpx_spu_rtn_ld;
    // Abort outranks a same-cycle return; anything not accepted in WAIT is reported as stale.
    assign accept_s = (state_r == ST_WAIT) & ret_s & ~abort_s;

    // State register
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.spu_mald_ldreq & bus.lsu_spu_ldreq_ack) state_nxt_s = ST_WAIT;
                    else                                            state_nxt_s = ST_IDLE;
                end
                ST_WAIT: begin
                    if (ret_s) state_nxt_s = bus.cpx_spu_rtn_unc ? ST_IDLE : ST_WR0;
                    else       state_nxt_s = ST_WAIT;
                end
                ST_WR0:  state_nxt_s = ST_WR1;
                ST_WR1:  state_nxt_s = ST_DONE;
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output decode: values the output registers take on the next edge
    always_comb begin
        wen_nxt_s    = (state_nxt_s == ST_WR0) | (state_nxt_s == ST_WR1);
        word_nxt_s   = (state_nxt_s == ST_WR1);
        ln_nxt_s     = (state_nxt_s == ST_DONE);
        inprog_nxt_s = (state_nxt_s == ST_WAIT) | (state_nxt_s == ST_WR0) | (state_nxt_s == ST_WR1);
        unc_nxt_s    = accept_s & bus.cpx_spu_rtn_unc;
        cor_nxt_s    = accept_s & bus.cpx_spu_rtn_cor;
        stale_nxt_s  = ret_s & ~accept_s;
    end

    // Line buffer, loaded only by an accepted return
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            buf_r <= {LINE_W{1'b0}};
        end else if (accept_s) begin
            buf_r <= bus.cpx_spu_rtn_data;
        end else begin
            buf_r <= buf_r;
        end
    end

    // Output registers
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wen_r    <= 1'b0;
            word_r   <= 1'b0;
            ln_r     <= 1'b0;
            unc_r    <= 1'b0;
            cor_r    <= 1'b0;
            inprog_r <= 1'b0;
            stale_r  <= 1'b0;
        end else begin
            wen_r    <= wen_nxt_s;
            word_r   <= word_nxt_s;
            ln_r     <= ln_nxt_s;
            unc_r    <= unc_nxt_s;
            cor_r    <= cor_nxt_s;
            inprog_r <= inprog_nxt_s;
            stale_r  <= stale_nxt_s;
        end
    end

    assign data_s  = word_r ? buf_r[WORD_W-1:0] : buf_r[LINE_W-1:WORD_W];
    assign wen1_s  = wen_r & ~abort_s;
    assign data1_s = wen1_s ? data_s : {WORD_W{1'b0}};

`ifdef SPU_LDRTN_PARITY_EN
    logic                wen_p_r;
    logic                word_p_r;
    logic                ln_p_r;
    logic [WORD_W-1:0]   data_p_r;
    logic [WORD_W/8-1:0] par_p_r;

    function automatic logic [WORD_W/8-1:0] byte_parity(input logic [WORD_W-1:0] d);
        byte_parity = {(WORD_W/8){1'b0}};
        for (int i = 0; i < WORD_W/8; i++) begin
            byte_parity[i] = ^d[8*i +: 8];
        end
    endfunction

    // Parity stage: write bus and line-received delayed together so parity stays aligned
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wen_p_r  <= 1'b0;
            word_p_r <= 1'b0;
            ln_p_r   <= 1'b0;
            data_p_r <= {WORD_W{1'b0}};
            par_p_r  <= {(WORD_W/8){1'b0}};
        end else begin
            wen_p_r  <= wen1_s;
            word_p_r <= word_r & wen1_s;
            ln_p_r   <= ln_r & ~abort_s;
            data_p_r <= data1_s;
            par_p_r  <= byte_parity(data1_s);
        end
    end

    assign wen_out_s               = wen_p_r & ~abort_s;
    assign word_out_s              = word_p_r & wen_out_s;
    assign data_out_s              = wen_out_s ? data_p_r : {WORD_W{1'b0}};
    assign ln_out_s                = ln_p_r & ~abort_s;
    assign bus.spu_ldrtn_memwr_par = wen_out_s ? par_p_r : {(WORD_W/8){1'b0}};
`else
    assign wen_out_s  = wen1_s;
    assign word_out_s = word_r & wen1_s;
    assign data_out_s = data1_s;
    assign ln_out_s   = ln_r & ~abort_s;
`endif

    assign bus.spu_ldrtn_memwen        = wen_out_s;
    assign bus.spu_ldrtn_memwr_word    = word_out_s;
    assign bus.spu_ldrtn_memwr_data    = data_out_s;
    assign bus.spu_ldrtn_ln_received   = ln_out_s;
    assign bus.spu_ldrtn_unc_err_pulse = unc_r & ~abort_s;
    assign bus.spu_ldrtn_cor_err_pulse = cor_r;
    assign bus.spu_ldrtn_ld_inprog     = inprog_r;
    assign bus.spu_ldrtn_stale_drop    = stale_r;
endmodule

// File: tb/tb_spu_ma_ldrtn.sv
// Self-checking bench for spu_ma_ldrtn: randomized lines against a timeline model of the return path.
module tb_spu_ma_ldrtn;
    localparam int LINE_W = 128;
    localparam int WORD_W = 64;
`ifdef SPU_LDRTN_PARITY_EN
    localparam int WOFF = 2;
`else
    localparam int WOFF = 1;
`endif
    localparam int LAT = WOFF + 2;

    logic rclk = 1'b0;
    logic arst_l;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] last_par0 = 8'h00;

    spu_ma_ldrtn_if #(.LINE_W(LINE_W), .WORD_W(WORD_W)) bus ();
    spu_ma_ldrtn #(.LINE_W(LINE_W), .WORD_W(WORD_W)) dut (.rclk(rclk), .arst_l(arst_l), .bus(bus));

    always #5 rclk = ~rclk;

    logic [WORD_W+6:0] all_outs;
    assign all_outs = {bus.spu_ldrtn_ln_received, bus.spu_ldrtn_unc_err_pulse, bus.spu_ldrtn_cor_err_pulse,
                       bus.spu_ldrtn_memwen, bus.spu_ldrtn_memwr_word, bus.spu_ldrtn_memwr_data,
                       bus.spu_ldrtn_ld_inprog, bus.spu_ldrtn_stale_drop};

    // Word idx 0 is the upper half of the line, idx 1 the lower half.
    function automatic logic [WORD_W-1:0] model_word(input logic [LINE_W-1:0] line, input int idx);
        logic [LINE_W-1:0] sh;
        sh = line >> (WORD_W * (1 - idx));
        return sh[WORD_W-1:0];
    endfunction

    function automatic logic [7:0] model_par(input logic [WORD_W-1:0] w);
        logic [7:0] p;
        p = 8'h00;
        for (int b = 0; b < 8; b++) begin
            int n;
            n = 0;
            for (int k = 0; k < 8; k++) n += int'((w >> (8*b + k)) & 64'd1);
            p[b] = (n % 2) == 1;
        end
        return p;
    endfunction

    task automatic idle_inputs();
        bus.spu_mald_ldreq    = 1'b0;
        bus.lsu_spu_ldreq_ack = 1'b0;
        bus.cpx_spu_rtn_vld   = 1'b0;
        bus.cpx_spu_rtn_ld    = 1'b0;
        bus.cpx_spu_rtn_data  = '0;
        bus.cpx_spu_rtn_unc   = 1'b0;
        bus.cpx_spu_rtn_cor   = 1'b0;
        bus.spu_ldrtn_abort   = 1'b0;
    endtask

    task automatic step();
        @(posedge rclk);
        #2;
    endtask

    task automatic drive_ret(input logic [LINE_W-1:0] line, input logic unc, input logic cor);
        bus.cpx_spu_rtn_vld  = 1'b1;
        bus.cpx_spu_rtn_ld   = 1'b1;
        bus.cpx_spu_rtn_data = line;
        bus.cpx_spu_rtn_unc  = unc;
        bus.cpx_spu_rtn_cor  = cor;
    endtask

    task automatic request();
        step(); idle_inputs();
        bus.spu_mald_ldreq = 1'b1; bus.lsu_spu_ldreq_ack = 1'b1;
        #1; checks++;
        if (bus.spu_ldrtn_ld_inprog !== 1'b0) begin
            failures++; $display("FAIL req_idle_inprog: got %0b expected 0", bus.spu_ldrtn_ld_inprog);
        end
        step(); idle_inputs();
        #1; checks++;
        if (bus.spu_ldrtn_ld_inprog !== 1'b1) begin
            failures++; $display("FAIL req_wait_inprog: got %0b expected 1", bus.spu_ldrtn_ld_inprog);
        end
    endtask

    task automatic run_line(input logic [LINE_W-1:0] line, input logic cor, input int gap, input bit noise);
        logic              e_wen, e_word, e_ln, e_cor, e_inprog;
        logic [WORD_W-1:0] e_data;
        request();
        for (int g = 0; g < gap; g++) begin
            step(); idle_inputs();
            if (noise) begin
                bus.spu_mald_ldreq = 1'($urandom_range(0, 1)); bus.lsu_spu_ldreq_ack = 1'($urandom_range(0, 1));
            end
            #1; checks++;
            if ({bus.spu_ldrtn_memwen, bus.spu_ldrtn_ld_inprog} !== 2'b01) begin
                failures++; $display("FAIL wait_state: got wen=%0b inprog=%0b expected 0/1", bus.spu_ldrtn_memwen, bus.spu_ldrtn_ld_inprog);
            end
        end
        step(); idle_inputs(); drive_ret(line, 1'b0, cor);
        if (noise) begin
            bus.spu_mald_ldreq = 1'b1; bus.lsu_spu_ldreq_ack = 1'b1;
        end
        #1;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(); idle_inputs();
            if (noise && k <= 2) begin
                bus.spu_mald_ldreq = 1'b1; bus.lsu_spu_ldreq_ack = 1'($urandom_range(0, 1));
            end
            #1;
            e_wen    = (k == WOFF) || (k == WOFF + 1);
            e_word   = (k == WOFF + 1);
            e_data   = e_wen ? model_word(line, k - WOFF) : '0;
            e_ln     = (k == LAT);
            e_cor    = (k == 1) && cor;
            e_inprog = (k < 3);
            checks++;
            if ({bus.spu_ldrtn_memwen, bus.spu_ldrtn_memwr_word, bus.spu_ldrtn_memwr_data} !== {e_wen, e_word, e_data}) begin
                failures++;
                $display("FAIL line_write k=%0d: got wen=%0b word=%0b data=%h expected wen=%0b word=%0b data=%h",
                         k, bus.spu_ldrtn_memwen, bus.spu_ldrtn_memwr_word, bus.spu_ldrtn_memwr_data, e_wen, e_word, e_data);
            end
            checks++;
            if ({bus.spu_ldrtn_ln_received, bus.spu_ldrtn_cor_err_pulse, bus.spu_ldrtn_unc_err_pulse, bus.spu_ldrtn_stale_drop}
                !== {e_ln, e_cor, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL line_pulses k=%0d: got ln/cor/unc/stale=%b%b%b%b expected %b%b00", k, bus.spu_ldrtn_ln_received,
                         bus.spu_ldrtn_cor_err_pulse, bus.spu_ldrtn_unc_err_pulse, bus.spu_ldrtn_stale_drop, e_ln, e_cor);
            end
            checks++;
            if (bus.spu_ldrtn_ld_inprog !== e_inprog) begin
                failures++; $display("FAIL line_inprog k=%0d: got %0b expected %0b", k, bus.spu_ldrtn_ld_inprog, e_inprog);
            end
`ifdef SPU_LDRTN_PARITY_EN
            if (k == WOFF) last_par0 = bus.spu_ldrtn_memwr_par;
            checks++;
            if (bus.spu_ldrtn_memwr_par !== (e_wen ? model_par(e_data) : 8'h00)) begin
                failures++; $display("FAIL line_par k=%0d: got %h expected %h", k, bus.spu_ldrtn_memwr_par,
                                     e_wen ? model_par(e_data) : 8'h00);
            end
`endif
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        arst_l = 1'b1;
        #1 arst_l = 1'b0;
        #3; checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        repeat (2) @(posedge rclk);
        @(negedge rclk); arst_l = 1'b1;
        step(); #1; checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL post_reset_idle: got %h expected 0", all_outs);
        end
    endtask

    task automatic test_nominal();
        run_line(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 2, 1'b0);
    endtask

    task automatic test_random_lines();
        repeat (6) begin
            run_line({$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    task automatic test_unc();
        request();
        step(); drive_ret({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b1);
        step(); idle_inputs(); #1; checks++;
        if ({bus.spu_ldrtn_unc_err_pulse, bus.spu_ldrtn_cor_err_pulse, bus.spu_ldrtn_memwen,
             bus.spu_ldrtn_ln_received, bus.spu_ldrtn_ld_inprog} !== 5'b11000) begin
            failures++; $display("FAIL unc_pulse: got unc/cor/wen/ln/inprog=%b%b%b%b%b expected 11000", bus.spu_ldrtn_unc_err_pulse,
                                 bus.spu_ldrtn_cor_err_pulse, bus.spu_ldrtn_memwen, bus.spu_ldrtn_ln_received, bus.spu_ldrtn_ld_inprog);
        end
        repeat (LAT + 1) begin
            step(); #1; checks++;
            if (all_outs !== '0) begin
                failures++; $display("FAIL unc_quiet: got %h expected 0", all_outs);
            end
        end
        step(); drive_ret(128'h1, 1'b0, 1'b0);
        step(); idle_inputs(); #1; checks++;
        if (bus.spu_ldrtn_stale_drop !== 1'b1) begin
            failures++; $display("FAIL unc_back_to_idle: got stale=%0b expected 1", bus.spu_ldrtn_stale_drop);
        end
    endtask

    task automatic test_abort_wr0();
        request();
        step(); drive_ret({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);
        step(); idle_inputs(); bus.spu_ldrtn_abort = 1'b1; #1; checks++;
        if ({bus.spu_ldrtn_memwen, bus.spu_ldrtn_memwr_data} !== '0) begin
            failures++; $display("FAIL abort_gate: got wen=%0b data=%h expected 0", bus.spu_ldrtn_memwen, bus.spu_ldrtn_memwr_data);
        end
        repeat (LAT + 1) begin
            step(); idle_inputs(); #1; checks++;
            if (all_outs !== '0) begin
                failures++; $display("FAIL abort_quiet: got %h expected 0", all_outs);
            end
        end
        run_line({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1, 1'b0);
    endtask

    task automatic test_stale();
        step(); drive_ret({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b1);
        step(); idle_inputs(); #1; checks++;
        if ({bus.spu_ldrtn_stale_drop, bus.spu_ldrtn_cor_err_pulse, bus.spu_ldrtn_memwen, bus.spu_ldrtn_ld_inprog} !== 4'b1000) begin
            failures++; $display("FAIL stale_idle: got stale/cor/wen/inprog=%b%b%b%b expected 1000", bus.spu_ldrtn_stale_drop,
                                 bus.spu_ldrtn_cor_err_pulse, bus.spu_ldrtn_memwen, bus.spu_ldrtn_ld_inprog);
        end
        step(); #1; checks++;
        if (bus.spu_ldrtn_stale_drop !== 1'b0) begin
            failures++; $display("FAIL stale_one_cycle: got %0b expected 0", bus.spu_ldrtn_stale_drop);
        end
        request();
        step(); bus.spu_ldrtn_abort = 1'b1;
        step(); idle_inputs(); #1; checks++;
        if (bus.spu_ldrtn_ld_inprog !== 1'b0) begin
            failures++; $display("FAIL abort_wait_inprog: got %0b expected 0", bus.spu_ldrtn_ld_inprog);
        end
        step(); drive_ret({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);
        step(); idle_inputs(); #1; checks++;
        if ({bus.spu_ldrtn_stale_drop, bus.spu_ldrtn_memwen} !== 2'b10) begin
            failures++; $display("FAIL stale_late_ret: got stale=%0b wen=%0b expected 1/0", bus.spu_ldrtn_stale_drop, bus.spu_ldrtn_memwen);
        end
        run_line({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        request();
        step(); drive_ret({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b1);
        step(); idle_inputs();
        step();
        #2 arst_l = 1'b0;
        #1; checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL async_reset_outputs: got %h expected 0", all_outs);
        end
        @(negedge rclk); arst_l = 1'b1;
        step(); #1; checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL async_reset_idle: got %h expected 0", all_outs);
        end
        run_line({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1, 1'b0);
    endtask

`ifdef SPU_LDRTN_PARITY_EN
    task automatic test_parity();
        run_line({64'h0100000000000003, $urandom(), $urandom()}, 1'b0, 1, 1'b0);
        checks++;
        if (last_par0 !== 8'h80) begin
            failures++; $display("FAIL parity_word0: got %h expected 80", last_par0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_random_lines();
        test_unc();
        test_abort_wr0();
        test_stale();
        test_async_reset();
`ifdef SPU_LDRTN_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
